add_exec_unit: RTL



---
 rtl/add_exec_pkg.sv | 19 +
 rtl/add_exec_unit_if.sv | 31 +++
 rtl/add_exec_unit_cdb_out_buffer.sv | 77 +++++++
 rtl/add_exec_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/add_exec_pkg.sv
// Shared types and constants for the ADD execution unit.
package add_exec_pkg;

   // Unit control states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXEC     = 2'd1,
      WAIT_CDB = 2'd2
   } state_e;

   localparam int DATA_W_DEF = 8;
   localparam int TAG_W_DEF  = 3;

   // Execute latency bounds; the down-counter is sized for LAT_MAX
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;
   localparam int CNT_W   = 4;

endpackage

// File: rtl/add_exec_unit_if.sv
// Station/CDB-side bus of the ADD execution unit.
// master = reservation station + CDB arbiter, slave = the unit.
interface add_exec_unit_if
   import add_exec_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
);
   logic              issue_valid;
   logic [DATA_W-1:0] ADD_Operand1;
   logic [DATA_W-1:0] ADD_Operand2;
   logic [TAG_W-1:0]  ADD_Tag_ip;
   logic              op_sub;
   logic              ADD_Status;
   logic              cdb_req;
   logic              cdb_grant;
   logic              cdb_valid;
   logic [DATA_W-1:0] cdb_data;
   logic [TAG_W-1:0]  cdb_tag;
   logic              cdb_carry;

   modport master (
      output issue_valid, ADD_Operand1, ADD_Operand2, ADD_Tag_ip, op_sub, cdb_grant,
      input  ADD_Status, cdb_req, cdb_valid, cdb_data, cdb_tag, cdb_carry
   );

   modport slave (
      input  issue_valid, ADD_Operand1, ADD_Operand2, ADD_Tag_ip, op_sub, cdb_grant,
      output ADD_Status, cdb_req, cdb_valid, cdb_data, cdb_tag, cdb_carry
   );
endinterface

// File: rtl/add_exec_unit_cdb_out_buffer.sv
// One-entry result buffer in front of the CDB with req/grant handshake.
// Only instantiated when ADD_OUTBUF_EN is defined.
module cdb_out_buffer #(
   parameter int DATA_W = 8,
   parameter int TAG_W  = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [TAG_W-1:0]  ld_tag,
   input  logic              ld_carry,
   input  logic              grant,
   output logic              req,
   output logic              cdb_valid,
   output logic [DATA_W-1:0] cdb_data,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic              cdb_carry
);
   logic              buf_vld_q, buf_vld_d;
   logic [DATA_W-1:0] buf_data_q, buf_data_d;
   logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
   logic              buf_carry_q, buf_carry_d;
   logic              out_vld_q, out_vld_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;
   logic              out_carry_q, out_carry_d;
   logic              fire;

   // Broadcast on grant; a load in the same edge refills the freed entry
   always_comb begin
      fire        = grant & buf_vld_q;
      buf_vld_d   = buf_vld_q & ~fire;
      buf_data_d  = buf_data_q;
      buf_tag_d   = buf_tag_q;
      buf_carry_d = buf_carry_q;
      out_vld_d   = fire;
      out_data_d  = fire ? buf_data_q  : out_data_q;
      out_tag_d   = fire ? buf_tag_q   : out_tag_q;
      out_carry_d = fire ? buf_carry_q : out_carry_q;
      if (load) begin
         buf_vld_d   = 1'b1;
         buf_data_d  = ld_data;
         buf_tag_d   = ld_tag;
         buf_carry_d = ld_carry;
      end
   end

   // Buffer and broadcast registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         buf_vld_q   <= 1'b0;
         buf_data_q  <= '0;
         buf_tag_q   <= '0;
         buf_carry_q <= 1'b0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         out_carry_q <= 1'b0;
      end else begin
         buf_vld_q   <= buf_vld_d;
         buf_data_q  <= buf_data_d;
         buf_tag_q   <= buf_tag_d;
         buf_carry_q <= buf_carry_d;
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         out_carry_q <= out_carry_d;
      end
   end

   assign req       = buf_vld_q;
   assign cdb_valid = out_vld_q;
   assign cdb_data  = out_data_q;
   assign cdb_tag   = out_tag_q;
   assign cdb_carry = out_carry_q;
endmodule

// File: rtl/add_exec_unit.sv
// ADD functional unit behind the ADD reservation station: latches one
// instruction, adds/subtracts over LATENCY cycles, then broadcasts on the CDB.
// Build option: ADD_OUTBUF_EN adds a 1-entry output buffer so the next issue
// can overlap the CDB wait.
module add_exec_unit
   import add_exec_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TAG_W   = TAG_W_DEF,
   parameter int LATENCY = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   add_exec_unit_if.slave bus
);
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic              sub_q, sub_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              carry_q, carry_d;
   logic [DATA_W:0]   sum;

   // Subtract is A + ~B + 1, so bit DATA_W reads as no-borrow
   always_comb begin
      sum = {1'b0, op_a_q} + {1'b0, (sub_q ? ~op_b_q : op_b_q)} + {{DATA_W{1'b0}}, sub_q};
   end

`ifdef ADD_OUTBUF_EN
   logic              buf_load;
   logic [DATA_W-1:0] buf_data;
   logic              buf_carry;
   logic [TAG_W-1:0]  buf_tag;
   logic              buf_req;
`endif

   // Next-state: issue latch, execute countdown, CDB hand-off
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sub_d   = sub_q;
      tag_d   = tag_q;
      res_d   = res_q;
      carry_d = carry_q;
`ifdef ADD_OUTBUF_EN
      buf_load  = 1'b0;
      buf_data  = res_q;
      buf_carry = carry_q;
      buf_tag   = tag_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.issue_valid) begin
               op_a_d  = bus.ADD_Operand1;
               op_b_d  = bus.ADD_Operand2;
               sub_d   = bus.op_sub;
               tag_d   = bus.ADD_Tag_ip;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
`ifdef ADD_OUTBUF_EN
               if (!buf_req) begin
                  // Buffer free: hand the result straight over
                  buf_load  = 1'b1;
                  buf_data  = sum[DATA_W-1:0];
                  buf_carry = sum[DATA_W];
                  state_d   = IDLE;
               end else begin
                  res_d   = sum[DATA_W-1:0];
                  carry_d = sum[DATA_W];
                  state_d = WAIT_CDB;
               end
`else
               res_d   = sum[DATA_W-1:0];
               carry_d = sum[DATA_W];
               state_d = WAIT_CDB;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT_CDB: begin
            if (bus.cdb_grant) begin
`ifdef ADD_OUTBUF_EN
               // Buffer drains this edge; refill it from the holding stage
               buf_load = 1'b1;
`endif
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and operand registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sub_q   <= 1'b0;
         tag_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sub_q   <= sub_d;
         tag_q   <= tag_d;
         res_q   <= res_d;
         carry_q <= carry_d;
      end
   end

   assign bus.ADD_Status = (state_q != IDLE);

`ifdef ADD_OUTBUF_EN
   cdb_out_buffer #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_outbuf (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (buf_load),
      .ld_data   (buf_data),
      .ld_tag    (buf_tag),
      .ld_carry  (buf_carry),
      .grant     (bus.cdb_grant),
      .req       (buf_req),
      .cdb_valid (bus.cdb_valid),
      .cdb_data  (bus.cdb_data),
      .cdb_tag   (bus.cdb_tag),
      .cdb_carry (bus.cdb_carry)
   );
   assign bus.cdb_req = buf_req;
`else
   logic              cdb_valid_q, cdb_valid_d;
   logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
   logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
   logic              cdb_carry_q, cdb_carry_d;

   // One-cycle broadcast on grant; payload holds between broadcasts
   always_comb begin
      cdb_valid_d = 1'b0;
      cdb_data_d  = cdb_data_q;
      cdb_tag_d   = cdb_tag_q;
      cdb_carry_d = cdb_carry_q;
      if (state_q == WAIT_CDB && bus.cdb_grant) begin
         cdb_valid_d = 1'b1;
         cdb_data_d  = res_q;
         cdb_tag_d   = tag_q;
         cdb_carry_d = carry_q;
      end
   end

   // Broadcast registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cdb_valid_q <= 1'b0;
         cdb_data_q  <= '0;
         cdb_tag_q   <= '0;
         cdb_carry_q <= 1'b0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_data_q  <= cdb_data_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_carry_q <= cdb_carry_d;
      end
   end

   assign bus.cdb_req   = (state_q == WAIT_CDB);
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_data  = cdb_data_q;
   assign bus.cdb_tag   = cdb_tag_q;
   assign bus.cdb_carry = cdb_carry_q;
`endif
endmodule
